restoring_div8: RTL and testbench



---
 rtl/div8_pkg.sv | 14 +
 rtl/div8_sub_stage.sv | 20 ++
 rtl/restoring_div8.sv | 114 +++++++++++
 tb/tb_restoring_div8.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/div8_pkg.sv
// Shared types and constants for the restoring divider.
// RESTORING_DIV8_EARLY_EXIT_EN (top level) sends divide-by-zero straight to DONE.
package div8_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

endpackage

// File: rtl/div8_sub_stage.sv
// Trial subtractor: one (WIDTH+1)-bit borrow chain, R - {0,D}.
// borrow_o high means the divisor did not fit into the partial remainder.
module div8_sub_stage
   import div8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   r_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH:0]   t_o,
   output logic             borrow_o
);

   logic [WIDTH+1:0] diff;

   assign diff     = {1'b0, r_i} - {2'b00, d_i};
   assign t_o      = diff[WIDTH:0];
   assign borrow_o = diff[WIDTH+1];

endmodule

// File: rtl/restoring_div8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define RESTORING_DIV8_EARLY_EXIT_EN to skip iterations for a zero divisor.
module restoring_div8
   import div8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic             borrow;

   assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

   div8_sub_stage #(
      .WIDTH(WIDTH)
   ) u_sub (
      .r_i      (r_sh),
      .d_i      (d_q),
      .t_o      (trial),
      .borrow_o (borrow)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               r_d     = '0;
               q_d     = dividend;
               d_d     = divisor;
               cnt_d   = '0;
               dbz_d   = (divisor == '0);
               state_d = CALC;
`ifdef RESTORING_DIV8_EARLY_EXIT_EN
               // Same result the full iteration would reach, without the wait.
               if (divisor == '0) begin
                  q_d     = '1;
                  r_d     = {1'b0, dividend};
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            q_d   = {q_q[WIDTH-2:0], ~borrow};
            r_d   = borrow ? r_sh : trial;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = q_q;
   assign remainder = r_q[WIDTH-1:0];
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_restoring_div8.sv
// Self-checking bench for restoring_div8: vector table, corner sequences,
// and a random stream scored against an arithmetic reference model.
module tb_restoring_div8;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       dbz;

   int passed = 0;
   int total  = 0;

`ifdef RESTORING_DIV8_EARLY_EXIT_EN
   localparam int DBZ_LAT = 0;
`else
   localparam int DBZ_LAT = 8;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[8];

   restoring_div8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Issue one operation from IDLE; returns outputs seen when out_valid
   // first appears and the number of edges after acceptance it took.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic rdy,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      dividend  = a;
      divisor   = b;
      out_ready = rdy;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
      q = quotient;
      r = remainder;
      z = dbz;
   endtask

   function automatic logic [16:0] model(input logic [7:0] a,
                                         input logic [7:0] b);
      if (b == 0) return {8'hFF, a, 1'b1};
      return {8'(a / b), 8'(a % b), 1'b0};
   endfunction

   initial begin
      logic [7:0]  q, r;
      logic        z;
      int          lat;
      logic [16:0] exp_q[$];
      logic [16:0] got, want;
      int          sent, recv, cyc;

      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
      vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
      vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
      vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8};
      vecs[4] = '{8'd100, 8'd0,   8'd255, 8'd100, 1'b1, DBZ_LAT};
      vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
      vecs[6] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0, 8};
      vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_quotient", int'(quotient), 0);
      check("rst_remainder", int'(remainder), 0);
      check("rst_dbz", int'(dbz), 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b1, q, r, z, lat);
         check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
         check($sformatf("vec%0d_r", i), int'(r), int'(vecs[i].r));
         check($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].z));
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         @(negedge clk);
         check($sformatf("vec%0d_idle", i), int'(in_ready), 1);
      end

      // Stalled consumer: result must hold.
      run_op(8'd200, 8'd7, 1'b0, q, r, z, lat);
      check("stall_q", int'(q), 28);
      check("stall_r", int'(r), 4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_hold", int'({quotient, remainder, dbz}),
               int'({q, r, z}));
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_out_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_in_ready", int'(in_ready), 1);
      check("stall_release_out_valid", int'(out_valid), 0);

      // Reset during the 4th CALC cycle.
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_quotient", int'(quotient), 0);
      check("abort_remainder", int'(remainder), 0);
      check("abort_dbz", int'(dbz), 0);
      run_op(8'd9, 8'd3, 1'b1, q, r, z, lat);
      check("after_abort_q", int'(q), 3);
      check("after_abort_r", int'(r), 0);
      check("after_abort_lat", lat, 8);

      // Random stream under random back-pressure.
      @(negedge clk);
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 1000 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (sent < 1000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            dividend = 8'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 1) == 1);
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(dividend, divisor));
            sent++;
         end
         if (out_valid && out_ready) begin
            got = {quotient, remainder, dbz};
            if (exp_q.size() == 0) begin
               check("rand_unexpected_result", int'(got), -1);
            end else begin
               want = exp_q.pop_front();
               check("rand_result", int'(got), int'(want));
            end
            recv++;
         end
      end
      check("rand_recv_count", recv, 1000);
      check("rand_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
